text_scan_addr_gen: RTL and testbench
=====================================

// Module: text_scan_addr_gen
//
// PURPOSE
//   Parametrised text-mode scan address generator, successor to the fixed
//   80x30 character/row counter.
//   - Walks pixel position -> glyph column, glyph row, text column, text row.
//   - Emits frame-buffer character address per active pixel.
//   - Adds hardware vertical scroll, cursor overlay detection and blink timing.
//   - Sits between the VGA timing generator and frame-buffer/glyph ROM lookup.
//
// PARAMETERS
//   COLS         80  text columns per row
//   ROWS         30  text rows per screen
//   GLYPH_W      8   glyph width in pixels (power of 2)
//   GLYPH_H      16  glyph height in pixels (power of 2)
//   ADDR_W       12  char_addr width; must hold COLS*ROWS-1
//   BLINK_FRAMES 16  frames per blink half-period (>=1)
//   Derived: CW=clog2(COLS), RW=clog2(ROWS), GWW=clog2(GLYPH_W), GHW=clog2(GLYPH_H)
//
// PORTS
//   CLK          in   1      pixel clock
//   RST_N        in   1      reset, asynchronous, active-low
//   frame_start  in   1      1-cycle pulse before first line of a frame
//   line_end     in   1      1-cycle pulse at end of each scanline
//   v_active     in   1      current line is in vertical active region
//   h_valid      in   1      current cycle is an active pixel
//   scroll_row   in   RW     physical row shown at top; sampled at frame_start
//   cursor_en    in   1      cursor overlay enable
//   cursor_col   in   CW     cursor text column (screen coords)
//   cursor_row   in   RW     cursor text row (screen coords, pre-scroll)
//   char_addr    out  ADDR_W frame-buffer character index
//   glyph_row    out  GHW    pixel row inside glyph
//   glyph_col    out  GWW    pixel column inside glyph
//   pix_valid    out  1      outputs correspond to an in-screen pixel
//   cursor_hit   out  1      current pixel lies in the visible cursor
//   blink        out  1      blink phase, toggles every BLINK_FRAMES frames
//
// BEHAVIOUR
//   - Reset (RST_N=0, async): every counter, register and output is 0.
//   - State: gcol, col, grow, trow (screen row), prow (physical row),
//     row_base = prow*COLS, scroll_lat.
//   - Outputs are registered; 1-cycle latency from the h_valid cycle.
//   - No multiplier in the per-pixel path. row_base advances by +COLS and
//     wraps to 0 when prow wraps ROWS-1 -> 0.
//
//   frame_start (highest priority; same-cycle line_end/h_valid ignored):
//   - Clear gcol, col, grow and trow.
//   - Latch scroll_lat = scroll_row; scroll_row >= ROWS is treated as 0.
//   - prow = scroll_lat; row_base = scroll_lat*COLS (one-time constant multiply).
//   - Next-cycle pix_valid=0.
//   - Advance the frame counter. On reaching BLINK_FRAMES-1: clear it and toggle blink.
//
//   h_valid and v_active:
//   - Register char_addr = row_base+col, glyph_row = grow, glyph_col = gcol.
//   - pix_valid = (col < COLS) && (trow < ROWS).
//   - gcol increments; on GLYPH_W-1 it wraps to 0 and col increments.
//   - col saturates at COLS. At COLS, pix_valid=0 and char_addr holds.
//
//   h_valid without v_active:
//   - pix_valid=0; counters unchanged.
//
//   Idle cycle (no h_valid):
//   - pix_valid=0; cursor_hit=0; other outputs hold.
//
//   line_end:
//   - Always clear gcol and col.
//   - If v_active and trow < ROWS: grow increments. On GLYPH_H-1 it wraps to 0
//     and trow increments. prow also increments, wrapping ROWS-1 -> 0.
//   - trow saturates at ROWS. Lines beyond the text area give pix_valid=0.
//   - line_end together with h_valid: the pixel is processed first, then the
//     line_end effects are applied.
//
//   cursor_hit (registered alongside pix_valid):
//   - Asserted when pix_valid, cursor_en, blink, col == cursor_col,
//     trow == cursor_row and grow >= GLYPH_H-2 (underline, bottom 2 rows)
//     are all true.
//
//   Mid-frame RST_N:
//   - Immediate clear. Resume at the next frame_start.
//   - Before that frame_start, counting restarts from 0 with scroll 0.
//
// TESTING
//   1. Default params, scroll 0, full 640x480 frame:
//      - Pixel (0,0) -> addr 0.
//      - Pixel (8,0) -> addr 1.
//      - Line 16, pixel 0 -> addr 80.
//      - Last pixel -> addr 2399, glyph_row 15, glyph_col 7.
//   2. scroll_row=28:
//      - Line 0 -> addr 2240.
//      - Line 32 -> addr 0 (wrap).
//      - Line 479 -> addr 2160+79=2239 at last pixel.
//   3. 648 h_valid pixels per line:
//      - Pixels 640..647 -> pix_valid=0, char_addr held at 79 (row 0).
//      - 496 active lines: lines 480..495 -> pix_valid=0.
//   4. Cursor (col 5, row 2), cursor_en=1, BLINK_FRAMES=2:
//      - cursor_hit=1 only on lines 46,47, pixels 40..47, in frames where blink=1.
//      - blink toggles every 2 frames.
//   5. Same-cycle events:
//      - frame_start with line_end -> counters zero, grow stays 0.
//      - scroll_row=31 at frame_start -> treated as 0.
//      - Changing scroll_row mid-frame -> no effect until the next frame_start.
//   6. RST_N low mid-line (async, between clock edges):
//      - All outputs 0 immediately.
//      - After release and frame_start, scenario 1 addresses reproduce exactly.

Source files
------------

// File: rtl/text_scan_addr_gen.sv
// Text-mode scan address generator: turns VGA pixel timing into character addresses
// and glyph coordinates, with hardware vertical scroll, underline cursor and blink.
module text_scan_addr_gen #(
    parameter int unsigned COLS         = 80,
    parameter int unsigned ROWS         = 30,
    parameter int unsigned GLYPH_W      = 8,
    parameter int unsigned GLYPH_H      = 16,
    parameter int unsigned ADDR_W       = 12,
    parameter int unsigned BLINK_FRAMES = 16,
    localparam int unsigned CW          = $clog2(COLS),
    localparam int unsigned RW          = $clog2(ROWS),
    localparam int unsigned GWW         = $clog2(GLYPH_W),
    localparam int unsigned GHW         = $clog2(GLYPH_H)
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              frame_start,
    input  logic              line_end,
    input  logic              v_active,
    input  logic              h_valid,
    input  logic [RW-1:0]     scroll_row,
    input  logic              cursor_en,
    input  logic [CW-1:0]     cursor_col,
    input  logic [RW-1:0]     cursor_row,
    output logic [ADDR_W-1:0] char_addr,
    output logic [GHW-1:0]    glyph_row,
    output logic [GWW-1:0]    glyph_col,
    output logic              pix_valid,
    output logic              cursor_hit,
    output logic              blink
);

    // Column/row counters need one extra code to saturate at COLS/ROWS.
    localparam int unsigned CCW = $clog2(COLS + 1);
    localparam int unsigned RCW = $clog2(ROWS + 1);
    localparam int unsigned FW  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [CCW-1:0]    COL_END   = CCW'(COLS);
    localparam logic [RCW-1:0]    ROW_END   = RCW'(ROWS);
    localparam logic [RW:0]       SCRL_END  = (RW + 1)'(ROWS);
    localparam logic [RW-1:0]     PROW_LAST = RW'(ROWS - 1);
    localparam logic [GWW-1:0]    GCOL_LAST = GWW'(GLYPH_W - 1);
    localparam logic [GHW-1:0]    GROW_LAST = GHW'(GLYPH_H - 1);
    localparam logic [GHW-1:0]    GROW_UL   = GHW'(GLYPH_H - 2);
    localparam logic [FW-1:0]     FCNT_LAST = FW'(BLINK_FRAMES - 1);
    localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(COLS);

    logic [GWW-1:0]    gcol_q, gcol_d;
    logic [CCW-1:0]    col_q, col_d;
    logic [GHW-1:0]    grow_q, grow_d;
    logic [RCW-1:0]    trow_q, trow_d;
    logic [RW-1:0]     prow_q, prow_d;
    logic [ADDR_W-1:0] row_base_q, row_base_d;
    logic [FW-1:0]     fcnt_q, fcnt_d;
    logic              blink_q, blink_d;
    logic [ADDR_W-1:0] char_addr_q, char_addr_d;
    logic [GHW-1:0]    glyph_row_q, glyph_row_d;
    logic [GWW-1:0]    glyph_col_q, glyph_col_d;
    logic              pix_valid_q, pix_valid_d;
    logic              cursor_hit_q, cursor_hit_d;

    logic [RW-1:0]     scroll_sel;
    logic [ADDR_W-1:0] scroll_base;
    logic              in_text;

    // Out-of-range scroll requests fall back to the top of the buffer.
    assign scroll_sel  = ({1'b0, scroll_row} >= SCRL_END) ? '0 : scroll_row;
    assign scroll_base = ADDR_W'(scroll_sel) * ROW_STEP;
    assign in_text     = (col_q < COL_END) && (trow_q < ROW_END);

    always_comb begin
        gcol_d       = gcol_q;
        col_d        = col_q;
        grow_d       = grow_q;
        trow_d       = trow_q;
        prow_d       = prow_q;
        row_base_d   = row_base_q;
        fcnt_d       = fcnt_q;
        blink_d      = blink_q;
        char_addr_d  = char_addr_q;
        glyph_row_d  = glyph_row_q;
        glyph_col_d  = glyph_col_q;
        pix_valid_d  = 1'b0;
        cursor_hit_d = 1'b0;

        if (frame_start) begin
            gcol_d     = '0;
            col_d      = '0;
            grow_d     = '0;
            trow_d     = '0;
            prow_d     = scroll_sel;
            row_base_d = scroll_base;
            if (fcnt_q == FCNT_LAST) begin
                fcnt_d  = '0;
                blink_d = ~blink_q;
            end else begin
                fcnt_d = fcnt_q + FW'(1);
            end
        end else begin
            if (h_valid && v_active) begin
                pix_valid_d  = in_text;
                glyph_row_d  = grow_q;
                glyph_col_d  = gcol_q;
                cursor_hit_d = in_text && cursor_en && blink_q &&
                               (col_q == CCW'(cursor_col)) &&
                               (trow_q == RCW'(cursor_row)) && (grow_q >= GROW_UL);
                if (in_text) begin
                    char_addr_d = row_base_q + ADDR_W'(col_q);
                end
                if (gcol_q == GCOL_LAST) begin
                    gcol_d = '0;
                    if (col_q < COL_END) begin
                        col_d = col_q + CCW'(1);
                    end
                end else begin
                    gcol_d = gcol_q + GWW'(1);
                end
            end

            // Applied after the pixel step so a pixel on the line_end cycle still counts.
            if (line_end) begin
                gcol_d = '0;
                col_d  = '0;
                if (v_active && (trow_q < ROW_END)) begin
                    if (grow_q == GROW_LAST) begin
                        grow_d = '0;
                        trow_d = trow_q + RCW'(1);
                        if (prow_q == PROW_LAST) begin
                            prow_d     = '0;
                            row_base_d = '0;
                        end else begin
                            prow_d     = prow_q + RW'(1);
                            row_base_d = row_base_q + ROW_STEP;
                        end
                    end else begin
                        grow_d = grow_q + GHW'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            gcol_q       <= '0;
            col_q        <= '0;
            grow_q       <= '0;
            trow_q       <= '0;
            prow_q       <= '0;
            row_base_q   <= '0;
            fcnt_q       <= '0;
            blink_q      <= 1'b0;
            char_addr_q  <= '0;
            glyph_row_q  <= '0;
            glyph_col_q  <= '0;
            pix_valid_q  <= 1'b0;
            cursor_hit_q <= 1'b0;
        end else begin
            gcol_q       <= gcol_d;
            col_q        <= col_d;
            grow_q       <= grow_d;
            trow_q       <= trow_d;
            prow_q       <= prow_d;
            row_base_q   <= row_base_d;
            fcnt_q       <= fcnt_d;
            blink_q      <= blink_d;
            char_addr_q  <= char_addr_d;
            glyph_row_q  <= glyph_row_d;
            glyph_col_q  <= glyph_col_d;
            pix_valid_q  <= pix_valid_d;
            cursor_hit_q <= cursor_hit_d;
        end
    end

    assign char_addr  = char_addr_q;
    assign glyph_row  = glyph_row_q;
    assign glyph_col  = glyph_col_q;
    assign pix_valid  = pix_valid_q;
    assign cursor_hit = cursor_hit_q;
    assign blink      = blink_q;

endmodule

// File: tb/tb_text_scan_addr_gen.sv
// Bench for text_scan_addr_gen: hand-computed probe table plus an arithmetic
// per-pixel reference, with hand sequences for same-cycle events and mid-frame reset.
module tb_text_scan_addr_gen;

    localparam int COLS = 80;
    localparam int ROWS = 30;
    localparam int GW   = 8;
    localparam int GH   = 16;
    localparam int AW   = 12;
    localparam int BF   = 2;

    logic          CLK = 1'b0;
    logic          RST_N = 1'b0;
    logic          frame_start = 1'b0;
    logic          line_end = 1'b0;
    logic          v_active = 1'b0;
    logic          h_valid = 1'b0;
    logic [4:0]    scroll_row = '0;
    logic          cursor_en = 1'b0;
    logic [6:0]    cursor_col = '0;
    logic [4:0]    cursor_row = '0;
    logic [AW-1:0] char_addr;
    logic [3:0]    glyph_row;
    logic [2:0]    glyph_col;
    logic          pix_valid;
    logic          cursor_hit;
    logic          blink;

    always #5 CLK = ~CLK;

    text_scan_addr_gen #(
        .COLS         (COLS),
        .ROWS         (ROWS),
        .GLYPH_W      (GW),
        .GLYPH_H      (GH),
        .ADDR_W       (AW),
        .BLINK_FRAMES (BF)
    ) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .frame_start (frame_start),
        .line_end    (line_end),
        .v_active    (v_active),
        .h_valid     (h_valid),
        .scroll_row  (scroll_row),
        .cursor_en   (cursor_en),
        .cursor_col  (cursor_col),
        .cursor_row  (cursor_row),
        .char_addr   (char_addr),
        .glyph_row   (glyph_row),
        .glyph_col   (glyph_col),
        .pix_valid   (pix_valid),
        .cursor_hit  (cursor_hit),
        .blink       (blink)
    );

    // Probe: expected outputs for the pixel at (line, px) of a given frame; -1 = don't care.
    typedef struct {
        int frame;
        int line;
        int px;
        int v;
        int addr;
        int grow;
        int gcol;
        int hit;
    } probe_t;

    probe_t probes[$];

    int checks = 0;
    int errors = 0;

    int m_line = 0, m_px = 0, m_scroll = 0, m_k = 0, m_hold = 0;
    int cur_frame = 0, frame_bad = 0, bad_line = 0, bad_px = 0;

    function automatic void add(input int f, input int l, input int p, input int v,
                                input int a, input int r, input int c, input int h);
        probe_t e;
        e.frame = f; e.line = l; e.px = p; e.v = v;
        e.addr = a;  e.grow = r; e.gcol = c; e.hit = h;
        probes.push_back(e);
    endfunction

    function automatic bit is_full(input int f, input int l);
        foreach (probes[i]) if (probes[i].frame == f && probes[i].line == l) return 1'b1;
        return 1'b0;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input logic fs, input logic le, input logic va, input logic hv);
        int  exp_a, exp_r, exp_c;
        bit  exp_v, exp_h, chk_a, bad;
        string loc;
        @(negedge CLK);
        frame_start = fs; line_end = le; v_active = va; h_valid = hv;
        @(posedge CLK);
        #1;
        exp_v = 1'b0; exp_h = 1'b0; chk_a = 1'b1; exp_a = m_hold; exp_r = -1; exp_c = -1;
        if (fs) begin
            m_line = 0;
            m_px = 0;
            m_scroll = (int'(scroll_row) >= ROWS) ? 0 : int'(scroll_row);
            m_k++;
        end else if (hv && va) begin
            exp_v = (m_px < COLS * GW) && (m_line < ROWS * GH);
            if (exp_v) begin
                exp_a = (((m_line / GH) + m_scroll) % ROWS) * COLS + m_px / GW;
                m_hold = exp_a;
                exp_r = m_line % GH;
                exp_c = m_px % GW;
                exp_h = cursor_en && (((m_k / BF) % 2) == 1) && (m_px / GW == int'(cursor_col))
                        && (m_line / GH == int'(cursor_row)) && (m_line % GH >= GH - 2);
            end else begin
                chk_a = (m_line < ROWS * GH);
            end
            foreach (probes[i]) begin
                if (probes[i].frame == cur_frame && probes[i].line == m_line &&
                    probes[i].px == m_px) begin
                    loc = $sformatf("f%0d l%0d p%0d", cur_frame, m_line, m_px);
                    check({loc, " pix_valid"}, int'(pix_valid), probes[i].v);
                    check({loc, " cursor_hit"}, int'(cursor_hit), probes[i].hit);
                    if (probes[i].addr >= 0)
                        check({loc, " char_addr"}, int'(char_addr), probes[i].addr);
                    if (probes[i].grow >= 0)
                        check({loc, " glyph_row"}, int'(glyph_row), probes[i].grow);
                    if (probes[i].gcol >= 0)
                        check({loc, " glyph_col"}, int'(glyph_col), probes[i].gcol);
                end
            end
            m_px++;
        end
        bad = (pix_valid !== exp_v) || (cursor_hit !== exp_h) ||
              (int'(blink) != (m_k / BF) % 2) ||
              (chk_a && int'(char_addr) != exp_a) ||
              (exp_r >= 0 && int'(glyph_row) != exp_r) ||
              (exp_c >= 0 && int'(glyph_col) != exp_c);
        if (bad) begin
            if (frame_bad == 0) begin
                bad_line = m_line;
                bad_px = m_px;
            end
            frame_bad++;
        end
        if (le && !fs) begin
            m_px = 0;
            if (va && m_line < ROWS * GH) m_line++;
        end
    endtask

    task automatic end_frame();
        checks++;
        if (frame_bad != 0) begin
            errors++;
            $display("FAIL frame_model f%0d: %0d bad cycles (first near line %0d px %0d), required 0",
                     cur_frame, frame_bad, bad_line, bad_px);
        end
    endtask

    // Lines carrying a probe get `width` pixels; others a short burst to keep runtime low.
    // Odd lines end with line_end on the last pixel, even lines with a separate idle cycle.
    task automatic run_frame(input int id, input int scroll, input int nlines, input int width,
                             input bit fs_busy, input int stop_line, input int stop_px);
        int  n;
        bit  stopped;
        cur_frame = id;
        frame_bad = 0;
        stopped = 1'b0;
        scroll_row = 5'(scroll);
        tick(1'b1, fs_busy, fs_busy, fs_busy);
        scroll_row = 5'(scroll + 9);
        for (int p = 0; p < 4; p++) tick(1'b0, 1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        for (int l = 0; l < nlines && !stopped; l++) begin
            n = is_full(id, l) ? width : 9;
            for (int p = 0; p < n && !stopped; p++) begin
                if (l == stop_line && p == stop_px) stopped = 1'b1;
                else tick(1'b0, (p == n - 1) && (l % 2 == 1), 1'b1, 1'b1);
            end
            if (!stopped && l % 2 == 0) tick(1'b0, 1'b1, 1'b1, 1'b0);
        end
        end_frame();
    endtask

    task automatic add_scenario1(input int f);
        add(f, 0, 0, 1, 0, 0, 0, 0);
        add(f, 0, 8, 1, 1, 0, 0, 0);
        add(f, 0, 639, 1, 79, 0, 7, 0);
        add(f, 15, 639, 1, 79, 15, 7, 0);
        add(f, 16, 0, 1, 80, 0, 0, 0);
        add(f, 479, 639, 1, 2399, 15, 7, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    initial begin
        add_scenario1(1);
        add(2, 0, 0, 1, 2240, 0, 0, 0);
        add(2, 16, 0, 1, 2320, 0, 0, 0);
        add(2, 32, 0, 1, 0, 0, 0, 0);
        add(2, 479, 639, 1, 2239, 15, 7, 0);
        add(3, 0, 639, 1, 79, 0, 7, 0);
        add(3, 0, 640, 0, 79, -1, -1, 0);
        add(3, 0, 647, 0, 79, -1, -1, 0);
        add(3, 479, 639, 1, 2399, 15, 7, 0);
        add(3, 480, 0, 0, -1, -1, -1, 0);
        add(3, 495, 647, 0, -1, -1, -1, 0);
        add(4, 46, 40, 1, 165, 14, 0, 0);
        add(5, 47, 47, 1, 165, 15, 7, 0);
        add(6, 46, 40, 1, 165, 14, 0, 1);
        add(6, 47, 47, 1, 165, 15, 7, 1);
        add(6, 46, 39, 1, 164, 14, 7, 0);
        add(6, 46, 48, 1, 166, 14, 0, 0);
        add(6, 45, 40, 1, 165, 13, 0, 0);
        add(7, 46, 40, 1, 565, 14, 0, 1);
        add(7, 47, 44, 1, 565, 15, 4, 1);
        add(8, 46, 40, 1, 165, 14, 0, 0);
        add(9, 0, 0, 1, 0, 0, 0, 0);
        add(9, 16, 0, 1, 80, 0, 0, 0);
        add(10, 40, 299, 1, 37, 8, 3, 0);
        add(12, 0, 0, 1, 0, 0, 0, 0);
        add(12, 0, 8, 1, 1, 0, 0, 0);
        add_scenario1(11);

        repeat (3) @(posedge CLK);
        #1;
        check("reset char_addr", int'(char_addr), 0);
        check("reset glyph_row", int'(glyph_row), 0);
        check("reset glyph_col", int'(glyph_col), 0);
        check("reset pix_valid", int'(pix_valid), 0);
        check("reset cursor_hit", int'(cursor_hit), 0);
        check("reset blink", int'(blink), 0);
        @(negedge CLK);
        RST_N = 1'b1;

        run_frame(1, 0, 480, 640, 1'b0, -1, -1);
        run_frame(2, 28, 480, 640, 1'b0, -1, -1);
        run_frame(3, 0, 496, 648, 1'b0, -1, -1);

        cursor_en = 1'b1; cursor_col = 7'd5; cursor_row = 5'd2;
        run_frame(4, 0, 48, 640, 1'b0, -1, -1);
        run_frame(5, 0, 48, 640, 1'b0, -1, -1);
        run_frame(6, 0, 48, 640, 1'b0, -1, -1);
        run_frame(7, 5, 48, 640, 1'b0, -1, -1);
        run_frame(8, 0, 47, 640, 1'b0, -1, -1);
        cursor_en = 1'b0;
        // frame_start together with line_end/h_valid while mid-glyph; scroll 31 is out of range
        run_frame(9, 31, 20, 640, 1'b1, -1, -1);

        cursor_en = 1'b1; cursor_col = 7'd37; cursor_row = 5'd2;
        run_frame(10, 28, 48, 640, 1'b0, 40, 300);
        #1;
        RST_N = 1'b0;
        frame_start = 1'b0; line_end = 1'b0; v_active = 1'b0; h_valid = 1'b0;
        #1;
        check("async rst char_addr", int'(char_addr), 0);
        check("async rst glyph_row", int'(glyph_row), 0);
        check("async rst glyph_col", int'(glyph_col), 0);
        check("async rst pix_valid", int'(pix_valid), 0);
        check("async rst cursor_hit", int'(cursor_hit), 0);
        check("async rst blink", int'(blink), 0);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
        cursor_en = 1'b0;
        m_line = 0; m_px = 0; m_scroll = 0; m_k = 0; m_hold = 0;

        // Counting resumes from zero with scroll 0 before any frame_start.
        cur_frame = 12;
        frame_bad = 0;
        for (int p = 0; p < 16; p++) tick(1'b0, p == 15, 1'b1, 1'b1);
        end_frame();

        run_frame(11, 0, 480, 640, 1'b0, -1, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
